// File: rtl/miriscv_mem_lat_model.sv
//==============================================================================
// Module      : miriscv_mem_lat_model
// Description : Dual-channel (fetch/data) fixed-latency memory responder over a
//               shared word array, with a testbench preload port.
//               Optional macro MIRISCV_MEM_MISALIGN_CHECK_EN adds misalign_err.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module miriscv_mem_lat_model #(
  parameter int                    INSTR_WIDTH = 64,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    LATENCY     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_req,
  input  logic [ADDR_WIDTH-1:0]        instr_addr,
  output logic                         instr_rvalid,
  output logic [INSTR_WIDTH-1:0]       instr_rdata,
  input  logic                         data_req,
  input  logic                         data_we,
  input  logic [DATA_WIDTH/8-1:0]      data_be,
  input  logic [ADDR_WIDTH-1:0]        data_addr,
  input  logic [DATA_WIDTH-1:0]        data_wdata,
  output logic                         data_rvalid,
  output logic [DATA_WIDTH-1:0]        data_rdata,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
  input  logic [DATA_WIDTH-1:0]        load_data
`ifdef MIRISCV_MEM_MISALIGN_CHECK_EN
  ,
  output logic                         misalign_err
`endif
);

  localparam int c_NB         = DATA_WIDTH / 8;
  localparam int c_BYTE_SHIFT = $clog2(c_NB);
  localparam int c_IDX_W      = $clog2(MEM_WORDS);
  localparam int c_K          = INSTR_WIDTH / DATA_WIDTH;

  logic [DATA_WIDTH-1:0]  r_mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0]  w_instr_off;
  logic [ADDR_WIDTH-1:0]  w_data_off;
  logic [c_IDX_W-1:0]     w_instr_idx;
  logic [c_IDX_W-1:0]     w_data_idx;
  logic [INSTR_WIDTH-1:0] w_fetch_word;
  logic                   w_store;
  logic                   w_load;
  logic                   w_unused_off;

  // Truncating the shifted offset to c_IDX_W bits gives the modulo wrap.
  assign w_instr_off  = instr_addr - BASE_ADDR;
  assign w_data_off   = data_addr - BASE_ADDR;
  assign w_instr_idx  = w_instr_off[c_BYTE_SHIFT +: c_IDX_W];
  assign w_data_idx   = w_data_off[c_BYTE_SHIFT +: c_IDX_W];
  assign w_store      = data_req & data_we;
  assign w_load       = data_req & ~data_we;
  assign w_unused_off = ^{w_instr_off, w_data_off};

  generate
    for (genvar i = 0; i < c_K; i++) begin : g_fetch_word
      assign w_fetch_word[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_instr_idx + c_IDX_W'(i)];
    end
  endgenerate

  // Array is never reset. The store is written after the preload so its
  // enabled bytes take priority when both hit the same word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_idx] <= load_data;
    end
    if (w_store) begin
      for (int b = 0; b < c_NB; b++) begin
        if (data_be[b]) begin
          r_mem[w_data_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
        end
      end
    end
  end

  logic                   r_ivalid [LATENCY];
  logic [INSTR_WIDTH-1:0] r_idata  [LATENCY];
  logic                   r_dvalid [LATENCY];
  logic [DATA_WIDTH-1:0]  r_ddata  [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_ivalid[s] <= 1'b0;
        r_idata[s]  <= '0;
        r_dvalid[s] <= 1'b0;
        r_ddata[s]  <= '0;
      end
    end else begin
      r_ivalid[0] <= instr_req;
      r_idata[0]  <= instr_req ? w_fetch_word : '0;
      r_dvalid[0] <= data_req;
      r_ddata[0]  <= w_load ? r_mem[w_data_idx] : '0;
      for (int s = 1; s < LATENCY; s++) begin
        r_ivalid[s] <= r_ivalid[s-1];
        r_idata[s]  <= r_idata[s-1];
        r_dvalid[s] <= r_dvalid[s-1];
        r_ddata[s]  <= r_ddata[s-1];
      end
    end
  end

  assign instr_rvalid = r_ivalid[LATENCY-1];
  assign instr_rdata  = r_idata[LATENCY-1];
  assign data_rvalid  = r_dvalid[LATENCY-1];
  assign data_rdata   = r_ddata[LATENCY-1];

`ifdef MIRISCV_MEM_MISALIGN_CHECK_EN
  localparam int c_FETCH_SHIFT = $clog2(INSTR_WIDTH / 8);

  logic w_instr_mis;
  logic w_data_mis;
  logic r_imis [LATENCY];
  logic r_dmis [LATENCY];

  assign w_instr_mis = instr_req & (instr_addr[c_FETCH_SHIFT-1:0] != '0);

  // Access size from data_be: all lanes = word, two lanes = half, else byte.
  always_comb begin
    w_data_mis = 1'b0;
    if (data_be == '1) begin
      w_data_mis = (data_addr[c_BYTE_SHIFT-1:0] != '0);
    end else if ($countones(data_be) == 2) begin
      w_data_mis = data_addr[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_imis[s] <= 1'b0;
        r_dmis[s] <= 1'b0;
      end
    end else begin
      r_imis[0] <= w_instr_mis;
      r_dmis[0] <= data_req & w_data_mis;
      for (int s = 1; s < LATENCY; s++) begin
        r_imis[s] <= r_imis[s-1];
        r_dmis[s] <= r_dmis[s-1];
      end
    end
  end

  assign misalign_err = r_imis[LATENCY-1] | r_dmis[LATENCY-1];
`else
  // No alignment checking is built in this configuration.
`endif

endmodule

`default_nettype wire
